// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
// Package     : common
// Description : Shared types for the global buffer and its sequencer:
//               buffer instruction encoding and sequencer FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

  // Instruction word presented on the global buffer's instruction port
  typedef enum logic [2:0] {
    I_NOP             = 3'd0,
    I_LOAD_WEIGHT     = 3'd1,
    I_LOAD_ACTIVATION = 3'd2,
    I_LOAD_OUTPUT     = 3'd3,
    I_POINTER_RESET   = 3'd4,
    I_READ_ACTIVATION = 3'd5
  } global_buffer_instruction_t;

  // Phases of one transfer program, in execution order
  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_LOAD_W = 3'd1,
    SEQ_LOAD_A = 3'd2,
    SEQ_RST1   = 3'd3,
    SEQ_LOAD_O = 3'd4,
    SEQ_RST2   = 3'd5,
    SEQ_READ_A = 3'd6,
    SEQ_DONE   = 3'd7
  } global_buffer_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/global_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : global_buffer_sequencer
// Description : Drives the global buffer instruction port through one fixed
//               transfer program: weight loads, activation loads, pointer
//               reset, output loads, pointer reset, activation reads.
//               Instructions issue only when buffer and data source agree.
// Revision    : 1.0 - initial release
// ============================================================================
module global_buffer_sequencer
  import common::*;
#(
  parameter int countWidth = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [countWidth-1:0]      n_weight_i,
  input  logic [countWidth-1:0]      n_act_i,
  input  logic [countWidth-1:0]      n_out_i,
  input  logic [countWidth-1:0]      n_read_i,
  output global_buffer_instruction_t gbuf_inst_o,
  input  logic                       gbuf_ready_i,
  input  logic                       ext_valid_i,
  output logic                       ext_ready_o,
  input  logic                       obuf_valid_i,
  output logic                       obuf_ready_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam logic [countWidth-1:0] c_zero = '0;
  localparam logic [countWidth-1:0] c_one  = countWidth'(1);

  global_buffer_seq_state_t r_state;
  global_buffer_seq_state_t w_state_next;
  logic [countWidth-1:0]    r_cnt_a;
  logic [countWidth-1:0]    r_cnt_o;
  logic [countWidth-1:0]    r_cnt_p;
  logic [countWidth-1:0]    r_remaining;
  logic [countWidth-1:0]    w_remaining_next;
  logic                     w_issue;
  logic                     w_last;

  // Weight count only matters at start, so it is used straight from the port
  // and never stored; the later phases need their latched counts.
  assign w_issue = (gbuf_inst_o != I_NOP);
  assign w_last  = (r_remaining == c_one);
  assign busy_o  = (r_state != SEQ_IDLE);

  // State and remaining-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_remaining <= c_zero;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
    end
  end

  // Latch the phase counts when a program is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_a <= c_zero;
      r_cnt_o <= c_zero;
      r_cnt_p <= c_zero;
    end else if (r_state == SEQ_IDLE && start_i && !abort_i) begin
      r_cnt_a <= n_act_i;
      r_cnt_o <= n_out_i;
      r_cnt_p <= n_read_i;
    end
  end

  // Next-state: advance on the last issue of a phase, skipping empty phases
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    if (abort_i) begin
      w_state_next     = SEQ_IDLE;
      w_remaining_next = c_zero;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (start_i) begin
            if (n_weight_i != c_zero) begin
              w_state_next     = SEQ_LOAD_W;
              w_remaining_next = n_weight_i;
            end else if (n_act_i != c_zero) begin
              w_state_next     = SEQ_LOAD_A;
              w_remaining_next = n_act_i;
            end else begin
              w_state_next     = SEQ_RST1;
              w_remaining_next = c_zero;
            end
          end
        end
        SEQ_LOAD_W: begin
          if (w_issue) begin
            if (!w_last) begin
              w_remaining_next = r_remaining - c_one;
            end else if (r_cnt_a != c_zero) begin
              w_state_next     = SEQ_LOAD_A;
              w_remaining_next = r_cnt_a;
            end else begin
              w_state_next     = SEQ_RST1;
              w_remaining_next = c_zero;
            end
          end
        end
        SEQ_LOAD_A: begin
          if (w_issue) begin
            if (!w_last) begin
              w_remaining_next = r_remaining - c_one;
            end else begin
              w_state_next     = SEQ_RST1;
              w_remaining_next = c_zero;
            end
          end
        end
        SEQ_RST1: begin
          if (w_issue) begin
            if (r_cnt_o != c_zero) begin
              w_state_next     = SEQ_LOAD_O;
              w_remaining_next = r_cnt_o;
            end else begin
              w_state_next = SEQ_RST2;
            end
          end
        end
        SEQ_LOAD_O: begin
          if (w_issue) begin
            if (!w_last) begin
              w_remaining_next = r_remaining - c_one;
            end else begin
              w_state_next     = SEQ_RST2;
              w_remaining_next = c_zero;
            end
          end
        end
        SEQ_RST2: begin
          if (w_issue) begin
            if (r_cnt_p != c_zero) begin
              w_state_next     = SEQ_READ_A;
              w_remaining_next = r_cnt_p;
            end else begin
              w_state_next = SEQ_DONE;
            end
          end
        end
        SEQ_READ_A: begin
          if (w_issue) begin
            if (!w_last) begin
              w_remaining_next = r_remaining - c_one;
            end else begin
              w_state_next     = SEQ_DONE;
              w_remaining_next = c_zero;
            end
          end
        end
        SEQ_DONE: begin
          w_state_next = SEQ_IDLE;
        end
        default: begin
          w_state_next     = SEQ_IDLE;
          w_remaining_next = c_zero;
        end
      endcase
    end
  end

  // Outputs: NOP unless the handshake for the current phase is met right now
  always_comb begin
    gbuf_inst_o  = I_NOP;
    ext_ready_o  = 1'b0;
    obuf_ready_o = 1'b0;
    done_o       = 1'b0;
    if (!abort_i) begin
      case (r_state)
        SEQ_LOAD_W: begin
          ext_ready_o = gbuf_ready_i;
          if (ext_valid_i && gbuf_ready_i) gbuf_inst_o = I_LOAD_WEIGHT;
        end
        SEQ_LOAD_A: begin
          ext_ready_o = gbuf_ready_i;
          if (ext_valid_i && gbuf_ready_i) gbuf_inst_o = I_LOAD_ACTIVATION;
        end
        SEQ_LOAD_O: begin
          obuf_ready_o = gbuf_ready_i;
          if (obuf_valid_i && gbuf_ready_i) gbuf_inst_o = I_LOAD_OUTPUT;
        end
        SEQ_RST1, SEQ_RST2: begin
          if (gbuf_ready_i) gbuf_inst_o = I_POINTER_RESET;
        end
        SEQ_READ_A: begin
          if (gbuf_ready_i) gbuf_inst_o = I_READ_ACTIVATION;
        end
        SEQ_DONE: begin
          done_o = 1'b1;
        end
        default: begin
          gbuf_inst_o = I_NOP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
